// File: rtl/vme_regbank_pkg.sv
// Shared address-class decode and response codes for the VME register bank.
// Optional lock register at index NUM_REGS+NUM_STAT is enabled by VME_REGBANK_LOCK_EN.
package vme_regbank_pkg;

    typedef enum logic [1:0] {
        ADR_CTRL     = 2'd0,
        ADR_STAT     = 2'd1,
        ADR_LOCK     = 2'd2,
        ADR_UNMAPPED = 2'd3
    } adr_class_e;

    localparam logic RESP_ACK = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Classify a word index into control, status, lock or unmapped space.
    function automatic adr_class_e decode_addr(
        input logic [31:0] k,
        input int unsigned num_regs,
        input int unsigned num_stat
    );
        adr_class_e cls;
        if (k < num_regs) begin
            cls = ADR_CTRL;
        end else if (k < num_regs + num_stat) begin
            cls = ADR_STAT;
`ifdef VME_REGBANK_LOCK_EN
        end else if (k == num_regs + num_stat) begin
            cls = ADR_LOCK;
`endif
        end else begin
            cls = ADR_UNMAPPED;
        end
        return cls;
    endfunction

endpackage

// File: rtl/vme_regbank_wr_pipe.sv
// Write request stage d0 plus write done/error generation and the optional lock bit.
// Lock register exists only when VME_REGBANK_LOCK_EN is defined.
module vme_regbank_wr_pipe
    import vme_regbank_pkg::*;
#(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned REG_W    = 16,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned NUM_STAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wr_data,
    output logic              ctrl_we_c,
    output logic [ADDR_W-1:0] wr_addr_c,
    output logic [REG_W-1:0]  wr_val_c,
    output logic              lock,
    output logic              wr_done,
    output logic              wr_error
);

    logic              d0_vld;
    logic [ADDR_W-1:0] d0_addr;
    logic [REG_W-1:0]  d0_data;
    adr_class_e        d0_cls_c;
    logic              lock_we_c;
    logic              err_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d0_vld  <= 1'b0;
            d0_addr <= '0;
            d0_data <= '0;
        end else begin
            d0_vld <= wr_mem;
            if (wr_mem) begin
                d0_addr <= addr;
                d0_data <= wr_data;
            end
        end
    end

    // Decode the captured request; a set lock turns control writes into errors.
    always_comb begin
        d0_cls_c  = decode_addr(32'(d0_addr), NUM_REGS, NUM_STAT);
        ctrl_we_c = 1'b0;
        lock_we_c = 1'b0;
        err_c     = RESP_ACK;
        if (d0_vld) begin
            case (d0_cls_c)
                ADR_CTRL: begin
                    if (lock) err_c = RESP_ERR;
                    else      ctrl_we_c = 1'b1;
                end
                ADR_LOCK: lock_we_c = 1'b1;
                default:  err_c = RESP_ERR;
            endcase
        end
    end

    assign wr_addr_c = d0_addr;
    assign wr_val_c  = d0_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_done  <= 1'b0;
            wr_error <= 1'b0;
        end else begin
            wr_done  <= d0_vld;
            wr_error <= err_c;
        end
    end

`ifdef VME_REGBANK_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock <= 1'b0;
        end else if (lock_we_c) begin
            lock <= d0_data[0];
        end
    end
`else
    logic unused_lock_we;
    assign unused_lock_we = lock_we_c;
    assign lock           = 1'b0;
`endif

endmodule

// File: rtl/vme_regbank_n.sv
// Parametrised VME register bank: RW control registers, RO status words, error responses.
// Define VME_REGBANK_LOCK_EN to add a write-lock register after the status words.
module vme_regbank_n
    import vme_regbank_pkg::*;
#(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_W    = 16,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned NUM_STAT = 2,
    parameter logic [NUM_REGS*REG_W-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         vme_addr,
    input  logic [DATA_W-1:0]         vme_wr_data,
    input  logic                      vme_rd_mem,
    input  logic                      vme_wr_mem,
    output logic [DATA_W-1:0]         vme_rd_data,
    output logic                      vme_rd_done,
    output logic                      vme_wr_done,
    output logic                      vme_rd_error,
    output logic                      vme_wr_error,
    output logic [NUM_REGS*REG_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]       wr_stb_o,
    input  logic [((NUM_STAT == 0) ? 1 : NUM_STAT*REG_W)-1:0] stat_i
);

    logic              ctrl_we_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [REG_W-1:0]  wr_val_c;
    logic              lock;
    adr_class_e        rd_cls_c;
    logic [REG_W-1:0]  rd_word_c;

    // Bits above REG_W carry no meaning for this bank.
    logic unused_wr_hi;
    assign unused_wr_hi = ^vme_wr_data;

    vme_regbank_wr_pipe #(
        .ADDR_W   (ADDR_W),
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS),
        .NUM_STAT (NUM_STAT)
    ) u_wr_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_mem    (vme_wr_mem),
        .addr      (vme_addr),
        .wr_data   (vme_wr_data[REG_W-1:0]),
        .ctrl_we_c (ctrl_we_c),
        .wr_addr_c (wr_addr_c),
        .wr_val_c  (wr_val_c),
        .lock      (lock),
        .wr_done   (vme_wr_done),
        .wr_error  (vme_wr_error)
    );

    // Control register array with per-register write strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_o   <= RST_VAL;
            wr_stb_o <= '0;
        end else begin
            wr_stb_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ctrl_we_c && wr_addr_c == ADDR_W'(i)) begin
                    regs_o[i*REG_W +: REG_W] <= wr_val_c;
                    wr_stb_o[i]              <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_cls_c  = decode_addr(32'(vme_addr), NUM_REGS, NUM_STAT);
        rd_word_c = '0;
        case (rd_cls_c)
            ADR_CTRL: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (vme_addr == ADDR_W'(i)) rd_word_c = regs_o[i*REG_W +: REG_W];
                end
            end
            ADR_STAT: begin
                for (int j = 0; j < NUM_STAT; j++) begin
                    if (vme_addr == ADDR_W'(NUM_REGS + j)) rd_word_c = stat_i[j*REG_W +: REG_W];
                end
            end
            ADR_LOCK: rd_word_c = REG_W'(lock);
            default:  rd_word_c = '0;
        endcase
    end

    // Read data holds between acknowledges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vme_rd_data  <= '0;
            vme_rd_done  <= 1'b0;
            vme_rd_error <= 1'b0;
        end else begin
            vme_rd_done  <= vme_rd_mem;
            vme_rd_error <= vme_rd_mem && (rd_cls_c == ADR_UNMAPPED);
            if (vme_rd_mem) vme_rd_data <= DATA_W'(rd_word_c);
        end
    end

endmodule

// File: tb/tb_vme_regbank_n.sv
// Scoreboard bench for vme_regbank_n; lock checks run when VME_REGBANK_LOCK_EN is defined.
module tb_vme_regbank_n;

    localparam logic [63:0] RST = 64'h000D_000C_000B_000A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] vme_addr;
    logic [31:0] vme_wr_data;
    logic        vme_rd_mem;
    logic        vme_wr_mem;
    logic [31:0] vme_rd_data;
    logic        vme_rd_done;
    logic        vme_wr_done;
    logic        vme_rd_error;
    logic        vme_wr_error;
    logic [63:0] regs_o;
    logic [3:0]  wr_stb_o;
    logic [31:0] stat_i;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [3:0]  stb;
        logic [63:0] regs;
    } wr_exp_t;

    rd_exp_t     rd_q[$];
    wr_exp_t     wr_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    vme_regbank_n #(
        .ADDR_W   (18),
        .DATA_W   (32),
        .REG_W    (16),
        .NUM_REGS (4),
        .NUM_STAT (2),
        .RST_VAL  (RST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vme_addr     (vme_addr),
        .vme_wr_data  (vme_wr_data),
        .vme_rd_mem   (vme_rd_mem),
        .vme_wr_mem   (vme_wr_mem),
        .vme_rd_data  (vme_rd_data),
        .vme_rd_done  (vme_rd_done),
        .vme_wr_done  (vme_wr_done),
        .vme_rd_error (vme_rd_error),
        .vme_wr_error (vme_wr_error),
        .regs_o       (regs_o),
        .wr_stb_o     (wr_stb_o),
        .stat_i       (stat_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pop expected responses as acknowledges appear.
    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (vme_rd_done) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected_done", 64'(vme_rd_done), 64'd0);
            end else begin
                re = rd_q.pop_front();
                chk("rd_cycle", 64'(cyc), 64'(re.cyc));
                chk("rd_data", 64'(vme_rd_data), 64'(re.data));
                chk("rd_error", 64'(vme_rd_error), 64'(re.err));
            end
        end
        if (vme_wr_done) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected_done", 64'(vme_wr_done), 64'd0);
            end else begin
                we = wr_q.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(we.cyc));
                chk("wr_error", 64'(vme_wr_error), 64'(we.err));
                chk("wr_stb", 64'(wr_stb_o), 64'(we.stb));
                chk("wr_regs", regs_o, we.regs);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        vme_rd_mem = 1'b0;
        vme_wr_mem = 1'b0;
    endtask

    task automatic rd(input logic [17:0] a, input logic [31:0] d, input logic e);
        rd_exp_t x;
        vme_addr   = a;
        vme_rd_mem = 1'b1;
        x.cyc  = cyc + 1;
        x.data = d;
        x.err  = e;
        rd_q.push_back(x);
    endtask

    task automatic wr(input logic [17:0] a, input logic [31:0] d, input logic e,
                      input logic [3:0] stb, input logic [63:0] regs);
        wr_exp_t x;
        vme_addr    = a;
        vme_wr_data = d;
        vme_wr_mem  = 1'b1;
        x.cyc  = cyc + 2;
        x.err  = e;
        x.stb  = stb;
        x.regs = regs;
        wr_q.push_back(x);
    endtask

    initial begin
        rst_n       = 1'b0;
        vme_addr    = '0;
        vme_wr_data = '0;
        vme_rd_mem  = 1'b0;
        vme_wr_mem  = 1'b0;
        stat_i      = {16'hBEEF, 16'h1111};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_regs", regs_o, RST);
        chk("reset_stb", 64'(wr_stb_o), 64'd0);
        chk("reset_rd_data", 64'(vme_rd_data), 64'd0);
        chk("reset_dones", 64'({vme_rd_done, vme_wr_done, vme_rd_error, vme_wr_error}), 64'd0);
        rst_n = 1'b1;
        step();

        rd(18'd0, 32'h0000_000A, 1'b0); step();
        rd(18'd1, 32'h0000_000B, 1'b0); step();
        rd(18'd2, 32'h0000_000C, 1'b0); step();
        rd(18'd3, 32'h0000_000D, 1'b0); step();

        wr(18'd2, 32'hFFFF_1234, 1'b0, 4'b0100, 64'h000D_1234_000B_000A); step(); step();
        rd(18'd2, 32'h0000_1234, 1'b0); step();

        rd(18'd4, 32'h0000_1111, 1'b0); step();
        rd(18'd5, 32'h0000_BEEF, 1'b0); step();
        wr(18'd5, 32'h0000_CAFE, 1'b1, 4'b0000, 64'h000D_1234_000B_000A); step();

        rd(18'h3FFFF, 32'h0, 1'b1); step();
        wr(18'h3FFFF, 32'h1, 1'b1, 4'b0000, 64'h000D_1234_000B_000A); step(); step();

        // Same-cycle read and write of register 1: read sees the old value.
        rd(18'd1, 32'h0000_000B, 1'b0);
        wr(18'd1, 32'h0000_0055, 1'b0, 4'b0010, 64'h000D_1234_0055_000A); step(); step();
        rd(18'd1, 32'h0000_0055, 1'b0); step();

        wr(18'd0, 32'h1, 1'b0, 4'b0001, 64'h000D_1234_0055_0001); step();
        wr(18'd1, 32'h2, 1'b0, 4'b0010, 64'h000D_1234_0002_0001); step();
        wr(18'd2, 32'h3, 1'b0, 4'b0100, 64'h000D_0003_0002_0001); step();
        wr(18'd3, 32'h4, 1'b0, 4'b1000, 64'h0004_0003_0002_0001); step(); step();

`ifdef VME_REGBANK_LOCK_EN
        rd(18'd6, 32'h0, 1'b0); step();
        wr(18'd6, 32'h1, 1'b0, 4'b0000, 64'h0004_0003_0002_0001); step(); step();
        wr(18'd0, 32'h99, 1'b1, 4'b0000, 64'h0004_0003_0002_0001); step();
        rd(18'd6, 32'h1, 1'b0); step();
        wr(18'd6, 32'h0, 1'b0, 4'b0000, 64'h0004_0003_0002_0001); step(); step();
        wr(18'd0, 32'h99, 1'b0, 4'b0001, 64'h0004_0003_0002_0099); step(); step();
        rd(18'd0, 32'h0000_0099, 1'b0); step();
`else
        rd(18'd6, 32'h0, 1'b1); step();
        wr(18'd6, 32'h1, 1'b1, 4'b0000, 64'h0004_0003_0002_0001); step();
        wr(18'd0, 32'h99, 1'b0, 4'b0001, 64'h0004_0003_0002_0099); step(); step();
        rd(18'd0, 32'h0000_0099, 1'b0); step();
`endif
        repeat (3) step();

        // Reset lands while a write sits in d0: no acknowledge, registers restored.
        vme_addr    = 18'd0;
        vme_wr_data = 32'h77;
        vme_wr_mem  = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_wr_done", 64'(vme_wr_done), 64'd0);
        chk("midrst_regs", regs_o, RST);
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_regs", regs_o, RST);
        rd(18'd0, 32'h0000_000A, 1'b0); step();
`ifdef VME_REGBANK_LOCK_EN
        rd(18'd6, 32'h0, 1'b0); step();
`endif
        repeat (4) step();

        while (rd_q.size() != 0) begin
            void'(rd_q.pop_front());
            chk("rd_timeout", 64'd1, 64'd0);
        end
        while (wr_q.size() != 0) begin
            void'(wr_q.pop_front());
            chk("wr_timeout", 64'd1, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
